// File: rtl/video_timing_gen.sv
// Video timing generator: pixel clock-enable divider plus horizontal/vertical
// counters with registered sync, blanking and line/frame strobes.
module video_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 256,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int H_BACK    = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_BOTTOM  = 14,
  parameter int V_SYNC    = 3,
  parameter int V_TOP     = 5,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  // Derived from the totals; not meant to be overridden.
  parameter int HW = $clog2(H_DISPLAY + H_FRONT + H_SYNC + H_BACK),
  parameter int VW = $clog2(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_ce,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          display_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // One bit wider than the counters so every boundary fits even with zero porches.
  localparam logic [HW:0] H_ACT_END  = (HW+1)'(H_DISPLAY);
  localparam logic [HW:0] H_SYNC_BEG = (HW+1)'(H_DISPLAY + H_FRONT);
  localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [VW:0] V_ACT_END  = (VW+1)'(V_DISPLAY);
  localparam logic [VW:0] V_SYNC_BEG = (VW+1)'(V_DISPLAY + V_BOTTOM);
  localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_DISPLAY + V_BOTTOM + V_SYNC);

  logic w_pix_ce;

  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

      logic [DW-1:0] r_div_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_div_cnt <= '0;
        end else if (enable) begin
          r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
        end
      end

      assign w_pix_ce = enable && !reset && (r_div_cnt == DIV_LAST);
    end else begin : g_nodiv
      assign w_pix_ce = enable && !reset;
    end
  endgenerate

  logic [HW-1:0] r_hpos;
  logic [VW-1:0] r_vpos;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_display_on;

  logic          w_h_last;
  logic          w_v_last;
  logic [HW-1:0] w_hpos_next;
  logic [VW-1:0] w_vpos_next;
  logic          w_hsync_act;
  logic          w_vsync_act;
  logic          w_display_next;

  assign w_h_last    = (r_hpos == H_LAST);
  assign w_v_last    = (r_vpos == V_LAST);
  assign w_hpos_next = w_h_last ? '0 : r_hpos + 1'b1;
  assign w_vpos_next = !w_h_last ? r_vpos : (w_v_last ? '0 : r_vpos + 1'b1);

  // Decoding the next position keeps the registered levels aligned with hpos/vpos.
  assign w_hsync_act = ({1'b0, w_hpos_next} >= H_SYNC_BEG) &&
                       ({1'b0, w_hpos_next} <  H_SYNC_END);
  assign w_vsync_act = ({1'b0, w_vpos_next} >= V_SYNC_BEG) &&
                       ({1'b0, w_vpos_next} <  V_SYNC_END);
  assign w_display_next = ({1'b0, w_hpos_next} < H_ACT_END) &&
                          ({1'b0, w_vpos_next} < V_ACT_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hpos       <= '0;
      r_vpos       <= '0;
      r_hsync      <= ~HSYNC_POL;
      r_vsync      <= ~VSYNC_POL;
      r_display_on <= 1'b1;
    end else if (w_pix_ce) begin
      r_hpos       <= w_hpos_next;
      r_vpos       <= w_vpos_next;
      r_hsync      <= w_hsync_act ? HSYNC_POL : ~HSYNC_POL;
      r_vsync      <= w_vsync_act ? VSYNC_POL : ~VSYNC_POL;
      r_display_on <= w_display_next;
    end
  end

  assign pix_ce      = w_pix_ce;
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign display_on  = r_display_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = w_pix_ce && (r_hpos == '0);
  assign frame_start = w_pix_ce && (r_hpos == '0) && (r_vpos == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default timing, a shrunken frame for wrap/vsync,
// and an undivided inverted-hsync variant with asynchronous reset.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default-parameter instance
  logic       rst0, en0;
  logic       d0_pix, d0_don, d0_hs, d0_vs, d0_ls, d0_fs;
  logic [8:0] d0_h, d0_v;

  video_timing_gen dut0 (
    .clk(clk), .reset(rst0), .enable(en0), .pix_ce(d0_pix), .hpos(d0_h),
    .vpos(d0_v), .display_on(d0_don), .hsync(d0_hs), .vsync(d0_vs),
    .line_start(d0_ls), .frame_start(d0_fs)
  );

  // Small frame: H_TOTAL=15, V_TOTAL=11, vsync active low on lines 8..9
  logic       rsts, ens;
  logic       ds_pix, ds_don, ds_hs, ds_vs, ds_ls, ds_fs;
  logic [3:0] ds_h, ds_v;

  video_timing_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .reset(rsts), .enable(ens), .pix_ce(ds_pix), .hpos(ds_h),
    .vpos(ds_v), .display_on(ds_don), .hsync(ds_hs), .vsync(ds_vs),
    .line_start(ds_ls), .frame_start(ds_fs)
  );

  // Undivided clock, active-low hsync
  logic       rst1, en1;
  logic       d1_pix, d1_don, d1_hs, d1_vs, d1_ls, d1_fs;
  logic [8:0] d1_h, d1_v;

  video_timing_gen #(.CLK_DIV(1), .HSYNC_POL(1'b0)) dut1 (
    .clk(clk), .reset(rst1), .enable(en1), .pix_ce(d1_pix), .hpos(d1_h),
    .vpos(d1_v), .display_on(d1_don), .hsync(d1_hs), .vsync(d1_vs),
    .line_start(d1_ls), .frame_start(d1_fs)
  );

  typedef struct {
    int   e;      // clk edges since reset release
    logic pix;
    int   h;
    int   v;
    logic hs;
    logic don;
    logic ls;
    logic fs;
  } vec_t;

  vec_t tbl[13];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int cur;
    int ls_cnt, ls_first, ls_second, hs_cnt, fs_cnt;
    int fs_first, fs_second, vs_cnt, pix_zero;

    tbl[0]  = '{0,   1'b0, 0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1,   1'b1, 0,   0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{2,   1'b0, 1,   0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{3,   1'b1, 1,   0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{511, 1'b1, 255, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{512, 1'b0, 256, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{525, 1'b1, 262, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{526, 1'b0, 263, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{571, 1'b1, 285, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{572, 1'b0, 286, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{617, 1'b1, 308, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{618, 1'b0, 0,   1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{619, 1'b1, 0,   1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst0 = 1'b1; rsts = 1'b1; rst1 = 1'b1;
    en0 = 1'b1; ens = 1'b1; en1 = 1'b1;
    tick(2);

    // Reset state while reset is held with enable=1
    chk("rst_pix", d0_pix, 0);
    chk("rst_hpos", d0_h, 0);
    chk("rst_vpos", d0_v, 0);
    chk("rst_hsync", d0_hs, 0);
    chk("rst_vsync", d0_vs, 0);
    chk("rst_display_on", d0_don, 1);
    chk("rst_line_start", d0_ls, 0);
    chk("rst_frame_start", d0_fs, 0);
    $display("reset state checked");

    rst0 = 1'b0;
    cur = 0;
    foreach (tbl[k]) begin
      tick(tbl[k].e - cur);
      cur = tbl[k].e;
      chk($sformatf("v%0d_pix", k), d0_pix, tbl[k].pix);
      chk($sformatf("v%0d_hpos", k), d0_h, tbl[k].h);
      chk($sformatf("v%0d_vpos", k), d0_v, tbl[k].v);
      chk($sformatf("v%0d_hsync", k), d0_hs, tbl[k].hs);
      chk($sformatf("v%0d_vsync", k), d0_vs, 0);
      chk($sformatf("v%0d_display_on", k), d0_don, tbl[k].don);
      chk($sformatf("v%0d_line_start", k), d0_ls, tbl[k].ls);
      chk($sformatf("v%0d_frame_start", k), d0_fs, tbl[k].fs);
      $display("vec %0d edge=%0d hpos=%0d vpos=%0d pix_ce=%0d hsync=%0d",
               k, tbl[k].e, d0_h, d0_v, d0_pix, d0_hs);
    end

    // Freeze inside the hsync pulse of line 1 with the divider at 0
    tick(1146 - cur);
    chk("pre_freeze_hpos", d0_h, 264);
    chk("pre_freeze_hsync", d0_hs, 1);
    en0 = 1'b0;
    #1;
    chk("freeze_pix_now", d0_pix, 0);
    for (int i = 0; i < 11; i++) begin
      tick(1);
      chk("freeze_pix", d0_pix, 0);
      chk("freeze_hpos", d0_h, 264);
      chk("freeze_vpos", d0_v, 1);
      chk("freeze_hsync", d0_hs, 1);
    end
    $display("freeze hpos=%0d vpos=%0d hsync=%0d", d0_h, d0_v, d0_hs);
    en0 = 1'b1;
    #1;
    chk("resume_pix0", d0_pix, 0);
    tick(1);
    chk("resume_pix1", d0_pix, 1);
    chk("resume_hpos1", d0_h, 264);
    tick(1);
    chk("resume_hpos2", d0_h, 265);
    $display("resume hpos=%0d", d0_h);

    // Mid-line async reset, then two full lines of statistics
    rst0 = 1'b1;
    #1;
    chk("async_rst0_hpos", d0_h, 0);
    chk("async_rst0_hsync", d0_hs, 0);
    tick(1);
    rst0 = 1'b0;
    ls_cnt = 0; ls_first = -1; ls_second = -1; hs_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 1236; i++) begin
      if (d0_ls) begin
        if (ls_cnt == 0) ls_first = i;
        else if (ls_cnt == 1) ls_second = i;
        ls_cnt++;
      end
      if (d0_hs) hs_cnt++;
      if (d0_fs) fs_cnt++;
      tick(1);
    end
    chk("line_start_count", ls_cnt, 2);
    chk("line_start_first", ls_first, 1);
    chk("line_period", ls_second - ls_first, 618);
    chk("hsync_clks_2lines", hs_cnt, 92);
    chk("frame_start_count_2lines", fs_cnt, 1);
    $display("lines: line_starts=%0d period=%0d hsync_clks=%0d",
             ls_cnt, ls_second - ls_first, hs_cnt);

    // Small frame: wrap, vsync and frame period
    chk("small_rst_vsync", ds_vs, 1);
    rsts = 1'b0;
    fs_cnt = 0; fs_first = -1; fs_second = -1; vs_cnt = 0;
    for (int i = 0; i < 660; i++) begin
      if (ds_fs) begin
        if (fs_cnt == 0) fs_first = i;
        else if (fs_cnt == 1) fs_second = i;
        fs_cnt++;
      end
      if (!ds_vs) vs_cnt++;
      case (i)
        16:  chk("small_don_h8v0", ds_don, 0);
        164: chk("small_don_h7v5", ds_don, 1);
        180: chk("small_don_h0v6", ds_don, 0);
        239: chk("small_vsync_v7", ds_vs, 1);
        240: chk("small_vsync_v8", ds_vs, 0);
        299: chk("small_vsync_v9", ds_vs, 0);
        300: chk("small_vsync_v10", ds_vs, 1);
        329: begin
          chk("small_last_hpos", ds_h, 14);
          chk("small_last_vpos", ds_v, 10);
          chk("small_last_pix", ds_pix, 1);
        end
        330: begin
          chk("small_wrap_hpos", ds_h, 0);
          chk("small_wrap_vpos", ds_v, 0);
          chk("small_wrap_pix", ds_pix, 0);
        end
        default: ;
      endcase
      tick(1);
    end
    chk("small_frame_start_count", fs_cnt, 2);
    chk("small_frame_start_first", fs_first, 1);
    chk("small_frame_period", fs_second - fs_first, 330);
    chk("small_vsync_clks", vs_cnt, 120);
    $display("small frame: frame_starts=%0d period=%0d vsync_clks=%0d",
             fs_cnt, fs_second - fs_first, vs_cnt);

    // Undivided clock, active-low hsync, async reset at (100,50)
    chk("div1_rst_pix", d1_pix, 0);
    chk("div1_rst_hsync", d1_hs, 1);
    rst1 = 1'b0;
    #1;
    chk("div1_first_pix", d1_pix, 1);
    chk("div1_first_fs", d1_fs, 1);
    pix_zero = 0;
    for (int i = 0; i <= 15550; i++) begin
      if (!d1_pix) pix_zero++;
      case (i)
        262: chk("div1_hsync_262", d1_hs, 1);
        263: chk("div1_hsync_263", d1_hs, 0);
        285: chk("div1_hsync_285", d1_hs, 0);
        286: chk("div1_hsync_286", d1_hs, 1);
        308: chk("div1_hpos_308", d1_h, 308);
        309: begin
          chk("div1_hpos_wrap", d1_h, 0);
          chk("div1_vpos_1", d1_v, 1);
        end
        default: ;
      endcase
      if (i < 15550) tick(1);
    end
    chk("div1_pix_always", pix_zero, 0);
    chk("div1_at_hpos", d1_h, 100);
    chk("div1_at_vpos", d1_v, 50);
    $display("div1 at hpos=%0d vpos=%0d", d1_h, d1_v);
    #2;
    rst1 = 1'b1;
    #1;
    chk("div1_async_hpos", d1_h, 0);
    chk("div1_async_vpos", d1_v, 0);
    chk("div1_async_pix", d1_pix, 0);
    chk("div1_async_ls", d1_ls, 0);
    chk("div1_async_fs", d1_fs, 0);
    chk("div1_async_hsync", d1_hs, 1);
    chk("div1_async_vsync", d1_vs, 0);
    chk("div1_async_don", d1_don, 1);
    $display("div1 async reset hpos=%0d vpos=%0d", d1_h, d1_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
